// File: rtl/dct8_odd_acc.sv
// -----------------------------------------------------------------------------
// dct8_odd_acc
//   Serial odd-part accumulator of the 8-point DCT-II. Takes the four odd
//   butterfly differences o0..o3 one per accepted beat, scales each by the
//   odd-row constants 89/75/50/18 with shift-add logic, and accumulates the
//   four odd outputs y1/y3/y5/y7. On the fourth beat the sums are rounded,
//   right-shifted by SHIFT, clipped to 16 bits and registered for output.
//
// Parameters
//   SHIFT      final right-shift applied to the sums (1..8)
//
// Ports
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a valid odd difference
//   in_ready   block can take in_data this cycle
//   in_data    12-bit signed odd difference, k = 0,1,2,3 in order
//   out_valid  out_y* hold a completed column
//   out_ready  downstream takes the outputs this cycle
//   out_y1..7  16-bit signed rounded, clipped odd coefficients
// -----------------------------------------------------------------------------
module dct8_odd_acc #(
  parameter int SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic        [11:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_y1,
  output logic signed [15:0] out_y3,
  output logic signed [15:0] out_y5,
  output logic signed [15:0] out_y7
);

  localparam logic signed [21:0] RND = 22'sd1 <<< (SHIFT - 1);

  // State
  logic        [1:0]  k_q, k_d;
  logic signed [20:0] acc1_q, acc3_q, acc5_q, acc7_q;
  logic signed [20:0] acc1_d, acc3_d, acc5_d, acc7_d;
  logic signed [15:0] y1_q, y3_q, y5_q, y7_q;
  logic signed [15:0] y1_d, y3_d, y5_d, y7_d;
  logic               out_valid_q, out_valid_d;

  // Handshake
  logic in_acc, out_acc, last_acc;

  assign in_ready = !(out_valid_q && !out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;
  assign last_acc = in_acc && (k_q == 2'd3);

  // Shift-add multiples of the input, 20-bit signed
  logic signed [19:0] x, m9, m25, m18, m50, m75, m89;

  assign x   = {{8{in_data[11]}}, in_data};
  assign m9  = x + (x <<< 3);
  assign m25 = m9 + (x <<< 4);
  assign m18 = m9 <<< 1;
  assign m50 = m25 <<< 1;
  assign m75 = (m25 <<< 2) - m25;   // 100x - 25x
  assign m89 = m25 + (x <<< 6);

  function automatic logic signed [20:0] ext(input logic signed [19:0] v);
    return {v[19], v};
  endfunction

  // Round half-up, arithmetic shift, saturate to 16 bits.
  function automatic logic signed [15:0] round_clip(input logic signed [20:0] s);
    logic signed [21:0] r;
    r = ($signed({s[20], s}) + RND) >>> SHIFT;
    if (r > 22'sd32767)       return 16'sh7fff;
    else if (r < -22'sd32768) return 16'sh8000;
    else                      return r[15:0];
  endfunction

  // Per-beat signed terms selected by the sample index
  logic signed [20:0] t1, t3, t5, t7;

  // NOTE: every signal driven from always_comb gets a default up front so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    t1 = '0;
    t3 = '0;
    t5 = '0;
    t7 = '0;
    unique case (k_q)
      2'd0: begin t1 =  ext(m89); t3 =  ext(m75); t5 =  ext(m50); t7 =  ext(m18); end
      2'd1: begin t1 =  ext(m75); t3 = -ext(m18); t5 = -ext(m89); t7 = -ext(m50); end
      2'd2: begin t1 =  ext(m50); t3 = -ext(m89); t5 =  ext(m18); t7 =  ext(m75); end
      2'd3: begin t1 =  ext(m18); t3 = -ext(m50); t5 =  ext(m75); t7 = -ext(m89); end
      default: ;
    endcase
  end

  // Next-state logic
  logic signed [20:0] s1, s3, s5, s7;

  assign s1 = acc1_q + t1;
  assign s3 = acc3_q + t3;
  assign s5 = acc5_q + t5;
  assign s7 = acc7_q + t7;

  always_comb begin
    k_d         = k_q;
    acc1_d      = acc1_q;
    acc3_d      = acc3_q;
    acc5_d      = acc5_q;
    acc7_d      = acc7_q;
    y1_d        = y1_q;
    y3_d        = y3_q;
    y5_d        = y5_q;
    y7_d        = y7_q;
    out_valid_d = out_valid_q;

    if (out_acc) out_valid_d = 1'b0;

    if (in_acc) begin
      k_d = k_q + 2'd1;   // wraps 3 -> 0
      if (last_acc) begin
        // Column complete: publish the results and start the next column
        // from zero. A simultaneous output accept is overridden here.
        acc1_d      = '0;
        acc3_d      = '0;
        acc5_d      = '0;
        acc7_d      = '0;
        y1_d        = round_clip(s1);
        y3_d        = round_clip(s3);
        y5_d        = round_clip(s5);
        y7_d        = round_clip(s7);
        out_valid_d = 1'b1;
      end else begin
        acc1_d = s1;
        acc3_d = s3;
        acc5_d = s5;
        acc7_d = s7;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      acc1_q      <= '0;
      acc3_q      <= '0;
      acc5_q      <= '0;
      acc7_q      <= '0;
      y1_q        <= '0;
      y3_q        <= '0;
      y5_q        <= '0;
      y7_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      acc1_q      <= acc1_d;
      acc3_q      <= acc3_d;
      acc5_q      <= acc5_d;
      acc7_q      <= acc7_d;
      y1_q        <= y1_d;
      y3_q        <= y3_d;
      y5_q        <= y5_d;
      y7_q        <= y7_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y1    = y1_q;
  assign out_y3    = y3_q;
  assign out_y5    = y5_q;
  assign out_y7    = y7_q;

endmodule

// File: tb/tb_dct8_odd_acc.sv
// -----------------------------------------------------------------------------
// tb_dct8_odd_acc
//   Directed bench for dct8_odd_acc. Two instances share the input stream:
//   dut_a with SHIFT=1 and dut_b with SHIFT=3. Inputs change 1 ns after the
//   rising edge and outputs are sampled there too, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_dct8_odd_acc;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic        [11:0] in_data;
  logic               out_ready;

  logic               a_in_ready, a_out_valid;
  logic signed [15:0] a_y1, a_y3, a_y5, a_y7;
  logic               b_in_ready, b_out_valid;
  logic signed [15:0] b_y1, b_y3, b_y5, b_y7;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dct8_odd_acc #(.SHIFT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_y1(a_y1), .out_y3(a_y3), .out_y5(a_y5), .out_y7(a_y7)
  );

  dct8_odd_acc #(.SHIFT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_y1(b_y1), .out_y3(b_y3), .out_y5(b_y5), .out_y7(b_y7)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one beat and advance to 1 ns past the next rising edge.
  task automatic beat(input logic v, input int d);
    in_valid = v;
    in_data  = d[11:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int y1, input int y3, input int y5, input int y7);
    check({tag, ".valid"}, int'(a_out_valid), 1);
    check({tag, ".y1"}, a_y1, y1);
    check({tag, ".y3"}, a_y3, y3);
    check({tag, ".y5"}, a_y5, y5);
    check({tag, ".y7"}, a_y7, y7);
  endtask

  // Golden model: plain multiplication, independent of the shift-add path.
  function automatic int model(input int c[4], input int x[4], input int sh);
    int s, r;
    s = 0;
    for (int i = 0; i < 4; i++) s += c[i] * x[i];
    r = (s + (1 << (sh - 1))) >>> sh;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  int c1[4] = '{89, 75, 50, 18};
  int c3[4] = '{75, -18, -89, -50};
  int c5[4] = '{50, -89, 18, 75};
  int c7[4] = '{18, -50, 75, -89};

  initial begin
    int col[4];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst.in_ready", int'(a_in_ready), 1);
    check("rst.out_valid", int'(a_out_valid), 0);
    check("rst.y1", a_y1, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.in_ready", int'(a_in_ready), 1);

    // Impulse, SHIFT=1
    beat(1'b1, 1); beat(1'b1, 0); beat(1'b1, 0);
    check("imp.valid_before", int'(a_out_valid), 0);
    beat(1'b1, 0);
    check_a("imp", 45, 38, 25, 9);
    beat(1'b0, 0);
    check("imp.consumed", int'(a_out_valid), 0);

    // Full-scale positive, SHIFT=3, including positive clip on y1
    repeat (4) beat(1'b1, 2047);
    check("max.valid", int'(b_out_valid), 1);
    check("max.y1", b_y1, 32767);
    check("max.y3", b_y3, -20982);
    check("max.y5", b_y5, 13817);
    check("max.y7", b_y7, -11770);

    // Full-scale negative, SHIFT=1: negative clip and floor rounding
    beat(1'b1, -2048); beat(1'b1, 0); beat(1'b1, 0); beat(1'b1, 0);
    check_a("neg", -32768, -32768, -32768, -18432);

    // Backpressure: result pending with out_ready low stalls the input
    beat(1'b1, 1); beat(1'b1, 0); beat(1'b1, 0);
    out_ready = 1'b0;
    beat(1'b1, 0);
    check_a("bp.first", 45, 38, 25, 9);
    in_data = 12'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.in_ready", int'(a_in_ready), 0);
      check("bp.valid", int'(a_out_valid), 1);
      check("bp.y1", a_y1, 45);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.consumed", int'(a_out_valid), 0);
    beat(1'b1, 0); beat(1'b1, 1); beat(1'b1, 0); beat(1'b1, 0);
    check_a("bp.next", 38, -9, -44, -25);
    beat(1'b0, 0);

    // Reset mid-column, asserted between edges
    beat(1'b1, 5); beat(1'b1, 7);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mrst.y1", a_y1, 0);
    check("mrst.valid", int'(a_out_valid), 0);
    check("mrst.in_ready", int'(a_in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 1); beat(1'b1, 0); beat(1'b1, 0); beat(1'b1, 0);
    check_a("mrst.after", 45, 38, 25, 9);

    // Streaming: 8 columns back-to-back
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        col[k] = int'($urandom_range(0, 4095)) - 2048;
        beat(1'b1, col[k]);
        if (k == 3) begin
          check("str.a_valid", int'(a_out_valid), 1);
          check("str.a_y1", a_y1, model(c1, col, 1));
          check("str.a_y3", a_y3, model(c3, col, 1));
          check("str.a_y5", a_y5, model(c5, col, 1));
          check("str.a_y7", a_y7, model(c7, col, 1));
          check("str.b_y1", b_y1, model(c1, col, 3));
          check("str.b_y3", b_y3, model(c3, col, 3));
          check("str.b_y5", b_y5, model(c5, col, 3));
          check("str.b_y7", b_y7, model(c7, col, 3));
        end else begin
          check("str.gap", int'(a_out_valid), 0);
          check("str.in_ready", int'(a_in_ready), 1);
        end
      end
    end
    beat(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
